score_sequencer: RTL

Parametrised music-score player. Walks a score ROM one entry at a time, decoding each entry into a note index, an octave band and a duration, and drives a one-hot note bus to the tone generators for that duration. Adds the following over the previous single-width reader:
- configurable field widths, tempo and ROM latency
- a note-off articulation gap
- rests and an end-of-score marker
- loop mode, edge-triggered play/pause and synchronous stop

Sits between the score ROM and the per-note tone generators.

---
 rtl/score_sequencer_if.sv | 29 ++
 rtl/score_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/score_sequencer_if.sv
// Handshake bundle between the score sequencer, its score ROM and the tone generators.
// master drives ROM data and player controls; slave is the sequencer itself.
interface score_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int NOTE_W = 4,
  parameter int BAND_W = 3,
  parameter int LEN_W  = 5
);
  logic [NOTE_W+BAND_W+LEN_W-1:0] rom_data;
  logic [ADDR_W-1:0]              rom_addr;
  logic                           play_btn;
  logic                           stop;
  logic                           loop_en;
  logic [(1<<NOTE_W)-1:0]         note_onehot;
  logic [BAND_W-1:0]              band;
  logic                           playing;
  logic                           note_start;
  logic                           done;

  modport master (
    output rom_data, play_btn, stop, loop_en,
    input  rom_addr, note_onehot, band, playing, note_start, done
  );

  modport slave (
    input  rom_data, play_btn, stop, loop_en,
    output rom_addr, note_onehot, band, playing, note_start, done
  );
endinterface

// File: rtl/score_sequencer.sv
// Score player: walks the score ROM, sounding each entry as a one-hot note for its
// duration followed by a note-off gap; supports rests, end marker, loop, pause and stop.
module score_sequencer #(
  parameter int CLK_HZ        = 50000000,
  parameter int TICKS_PER_SEC = 16,
  parameter int ADDR_W        = 16,
  parameter int NOTE_W        = 4,
  parameter int BAND_W        = 3,
  parameter int LEN_W         = 5,
  parameter int ROM_LAT       = 1,
  parameter int GAP_CYCLES    = 2500000
) (
  input logic              clk,
  input logic              rst_n,
  score_sequencer_if.slave bus
);
  // state | meaning
  // IDLE  | stopped, waiting for a play edge
  // FETCH | address presented, wait ROM_LAT cycles then decode the entry
  // PLAY  | note (or rest) sounding for len*UNIT-GAP_CYCLES cycles
  // GAP   | note-off articulation, then advance to the next entry
  // END   | end marker reached without loop, waiting for a play edge

  localparam int          UNIT      = CLK_HZ / TICKS_PER_SEC;
  localparam int          NUM_NOTES = 1 << NOTE_W;
  localparam longint      MAX_DUR   = ((longint'(1) << LEN_W) - 1) * longint'(UNIT);
  localparam logic [31:0] UNIT_C    = 32'(UNIT);
  localparam logic [31:0] GAP_C     = 32'(GAP_CYCLES);
  localparam logic [31:0] LAT_C     = 32'(ROM_LAT - 1);

  if (GAP_CYCLES >= UNIT) begin : g_chk_gap
    $error("score_sequencer: GAP_CYCLES must be below one duration unit");
  end
  if (MAX_DUR > 64'sd4294967295) begin : g_chk_dur
    $error("score_sequencer: longest duration does not fit the 32-bit counter");
  end
  if (ROM_LAT < 1) begin : g_chk_lat
    $error("score_sequencer: ROM_LAT must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_END} state_t;

  state_t                state;
  logic                  run_q;
  logic                  btn_q;
  logic [31:0]           cnt;
  logic [ADDR_W-1:0]     rom_addr_q;
  logic [NOTE_W-1:0]     note_q;
  logic [BAND_W-1:0]     band_q;
  logic [NUM_NOTES-1:0]  onehot_q;
  logic                  playing_q;
  logic                  note_start_q;
  logic                  done_q;

  logic                  rise;
  logic                  run_eff;
  logic [NOTE_W-1:0]     ent_note;
  logic [BAND_W-1:0]     ent_band;
  logic [LEN_W-1:0]      ent_len;

  assign ent_len  = bus.rom_data[LEN_W-1:0];
  assign ent_band = bus.rom_data[LEN_W +: BAND_W];
  assign ent_note = bus.rom_data[LEN_W+BAND_W +: NOTE_W];

  // run as it will be after this edge, before stop or end-of-score override it
  assign rise    = bus.play_btn & ~btn_q;
  assign run_eff = run_q ^ rise;

  function automatic logic [NUM_NOTES-1:0] decode(input logic [NOTE_W-1:0] n);
    logic [NUM_NOTES-1:0] d;
    d = '0;
    if (n != '0) d[n] = 1'b1;
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      run_q        <= 1'b0;
      btn_q        <= 1'b0;
      cnt          <= '0;
      rom_addr_q   <= '0;
      note_q       <= '0;
      band_q       <= '0;
      onehot_q     <= '0;
      playing_q    <= 1'b0;
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      btn_q        <= bus.play_btn;
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (bus.stop) begin
        state      <= S_IDLE;
        run_q      <= 1'b0;
        cnt        <= '0;
        rom_addr_q <= '0;
        note_q     <= '0;
        band_q     <= '0;
        onehot_q   <= '0;
        playing_q  <= 1'b0;
      end else begin
        run_q <= run_eff;
        case (state)
          S_IDLE, S_END: begin
            playing_q <= run_eff;
            onehot_q  <= '0;
            if (run_eff) begin
              state      <= S_FETCH;
              rom_addr_q <= '0;
              cnt        <= LAT_C;
            end
          end
          S_FETCH: begin
            playing_q <= run_eff;
            onehot_q  <= '0;
            if (run_q) begin
              if (cnt != '0) begin
                cnt <= cnt - 32'd1;
              end else if (ent_len == '0) begin
                rom_addr_q <= '0;
                if (bus.loop_en) begin
                  cnt <= LAT_C;
                end else begin
                  state     <= S_END;
                  run_q     <= 1'b0;
                  playing_q <= 1'b0;
                  done_q    <= 1'b1;
                end
              end else begin
                state        <= S_PLAY;
                note_q       <= ent_note;
                band_q       <= ent_band;
                cnt          <= 32'(ent_len) * UNIT_C - GAP_C - 32'd1;
                onehot_q     <= run_eff ? decode(ent_note) : '0;
                note_start_q <= 1'b1;
              end
            end
          end
          S_PLAY: begin
            playing_q <= run_eff;
            onehot_q  <= run_eff ? decode(note_q) : '0;
            if (run_q) begin
              if (cnt != '0) begin
                cnt <= cnt - 32'd1;
              end else if (GAP_CYCLES == 0) begin
                state      <= S_FETCH;
                rom_addr_q <= rom_addr_q + ADDR_W'(1);
                cnt        <= LAT_C;
                onehot_q   <= '0;
              end else begin
                state    <= S_GAP;
                cnt      <= GAP_C - 32'd1;
                onehot_q <= '0;
              end
            end
          end
          S_GAP: begin
            playing_q <= run_eff;
            onehot_q  <= '0;
            if (run_q) begin
              if (cnt != '0) begin
                cnt <= cnt - 32'd1;
              end else begin
                state      <= S_FETCH;
                rom_addr_q <= rom_addr_q + ADDR_W'(1);
                cnt        <= LAT_C;
              end
            end
          end
          default: begin
            state     <= S_IDLE;
            onehot_q  <= '0;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.note_onehot = onehot_q;
  assign bus.band        = band_q;
  assign bus.playing     = playing_q;
  assign bus.note_start  = note_start_q;
  assign bus.done        = done_q;
endmodule
